axis_frame_gen: RTL and testbench

Synthetic 10G Ethernet traffic source for the SFP demo. It builds Ethernet frames (without FCS) on a 64-bit AXI-Stream master interface that feeds the nfmac10g transmit port inside the system block design. Frame length and inter-frame gap are programmable at run time. A sequence number in every frame lets a downstream checker detect loss and reordering.

---
 rtl/axis_frame_gen_if.sv | 19 +
 rtl/axis_frame_gen.sv | 213 +++++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_gen_if.sv
// 64-bit AXI-Stream transmit bundle between the frame generator and the MAC.
interface axis_frame_gen_if;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic        tx_tvalid;
  logic        tx_tready;
  logic        tx_tlast;
  logic        tx_tuser;

  modport master (
    output tx_tdata, tx_tkeep, tx_tvalid, tx_tlast, tx_tuser,
    input  tx_tready
  );

  modport slave (
    input  tx_tdata, tx_tkeep, tx_tvalid, tx_tlast, tx_tuser,
    output tx_tready
  );
endinterface

// File: rtl/axis_frame_gen.sv
// Synthetic Ethernet frame source: programmable length/gap, sequence-numbered
// payload, 64-bit AXI-Stream output with every output driven from a register.
module axis_frame_gen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h000A_3500_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               enable,
  input  logic [10:0]        frame_len,
  input  logic [15:0]        gap_cycles,
  axis_frame_gen_if.master   m_axis,
  output logic [31:0]        frame_count,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [10:0] r_len;
  logic [15:0] r_gap;
  logic [15:0] r_gap_cnt;
  logic [7:0]  r_beat;
  logic [31:0] r_seq;
  logic [31:0] r_count;
  logic [63:0] r_tdata;
  logic [7:0]  r_tkeep;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_busy;

  logic        w_hs;
  logic [10:0] w_len_c;
  logic [31:0] w_seq_inc;
  logic [7:0]  w_ld_k;
  logic [10:0] w_ld_len;
  logic [31:0] w_ld_seq;
  logic [63:0] w_ld_data;
  logic [7:0]  w_ld_keep;
  logic        w_ld_last;

  function automatic logic [10:0] clamp_len(input logic [10:0] l);
    if (l < 11'd60)
      return 11'd60;
    else if (l > 11'd1514)
      return 11'd1514;
    else
      return l;
  endfunction

  function automatic logic beat_is_last(input logic [7:0] k, input logic [10:0] len);
    logic [10:0] last_idx;
    last_idx = (len - 11'd1) >> 3;
    return ({3'b000, k} == last_idx);
  endfunction

  function automatic logic [7:0] beat_keep(input logic [7:0] k, input logic [10:0] len);
    if (beat_is_last(k, len) && (len[2:0] != 3'd0))
      return 8'hFF >> (4'd8 - {1'b0, len[2:0]});
    else
      return 8'hFF;
  endfunction

  // Header bytes 0..17 come from the packed header vector, payload byte i is i[7:0].
  function automatic logic [63:0] beat_data(input logic [7:0] k, input logic [10:0] len,
                                            input logic [31:0] seq);
    logic [143:0] hdr;
    logic [10:0]  idx;
    logic [7:0]   b;
    logic [63:0]  d;
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE, seq};
    d   = 64'd0;
    for (int j = 0; j < 8; j++) begin
      idx = {k, 3'b000} + 11'(j);
      if (idx < 11'd18)
        b = 8'(hdr >> ((8'd17 - idx[7:0]) * 8'd8));
      else
        b = idx[7:0];
      if (idx >= len)
        b = 8'h00;
      d[j*8 +: 8] = b;
    end
    return d;
  endfunction

  assign w_hs      = r_tvalid & m_axis.tx_tready;
  assign w_len_c   = clamp_len(frame_len);
  assign w_seq_inc = r_seq + 32'd1;

  // Select which beat gets loaded into the output register on the next handshake/start.
  always_comb begin
    w_ld_k   = r_beat + 8'd1;
    w_ld_len = r_len;
    w_ld_seq = r_seq;
    if (r_state == S_SEND && !r_tvalid) begin
      w_ld_k = 8'd0;
    end else if (r_state == S_SEND && r_tlast) begin
      w_ld_k   = 8'd0;
      w_ld_len = w_len_c;
      w_ld_seq = w_seq_inc;
    end else if (r_state == S_GAP) begin
      w_ld_k   = 8'd0;
      w_ld_len = w_len_c;
    end else begin
      w_ld_k = r_beat + 8'd1;
    end
    w_ld_data = beat_data(w_ld_k, w_ld_len, w_ld_seq);
    w_ld_keep = beat_keep(w_ld_k, w_ld_len);
    w_ld_last = beat_is_last(w_ld_k, w_ld_len);
  end

  // Frame FSM with registered stream outputs, counters and sequence number.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_len     <= 11'd60;
      r_gap     <= 16'd0;
      r_gap_cnt <= 16'd0;
      r_beat    <= 8'd0;
      r_seq     <= 32'd0;
      r_count   <= 32'd0;
      r_tdata   <= 64'd0;
      r_tkeep   <= 8'd0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_len   <= w_len_c;
            r_gap   <= gap_cycles;
            r_beat  <= 8'd0;
            r_busy  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (!r_tvalid) begin
            r_beat   <= 8'd0;
            r_tdata  <= w_ld_data;
            r_tkeep  <= w_ld_keep;
            r_tlast  <= w_ld_last;
            r_tvalid <= 1'b1;
          end else if (w_hs && r_tlast) begin
            r_count <= r_count + 32'd1;
            r_seq   <= w_seq_inc;
            if (r_gap == 16'd0 && enable) begin
              // Back-to-back: next frame's first beat replaces the last one, valid stays high.
              r_len   <= w_len_c;
              r_gap   <= gap_cycles;
              r_beat  <= 8'd0;
              r_tdata <= w_ld_data;
              r_tkeep <= w_ld_keep;
              r_tlast <= w_ld_last;
            end else begin
              r_tvalid  <= 1'b0;
              r_tlast   <= 1'b0;
              r_tdata   <= 64'd0;
              r_tkeep   <= 8'd0;
              r_gap_cnt <= r_gap;
              r_busy    <= (r_gap != 16'd0);
              r_state   <= (r_gap != 16'd0) ? S_GAP : S_IDLE;
            end
          end else if (w_hs) begin
            r_beat  <= w_ld_k;
            r_tdata <= w_ld_data;
            r_tkeep <= w_ld_keep;
            r_tlast <= w_ld_last;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 16'd1) begin
            if (enable) begin
              r_len    <= w_len_c;
              r_gap    <= gap_cycles;
              r_beat   <= 8'd0;
              r_tdata  <= w_ld_data;
              r_tkeep  <= w_ld_keep;
              r_tlast  <= w_ld_last;
              r_tvalid <= 1'b1;
              r_state  <= S_SEND;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
          end
        end
        default: begin
          r_tvalid <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign m_axis.tx_tdata  = r_tdata;
  assign m_axis.tx_tkeep  = r_tkeep;
  assign m_axis.tx_tvalid = r_tvalid;
  assign m_axis.tx_tlast  = r_tlast;
  assign m_axis.tx_tuser  = 1'b0;
  assign frame_count      = r_count;
  assign busy             = r_busy;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: stimulus queues expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_axis_frame_gen;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable  = 1'b0;
  logic [10:0] frame_len  = 11'd60;
  logic [15:0] gap_cycles = 16'd0;
  logic [31:0] frame_count;
  logic        busy;

  axis_frame_gen_if axis_if();

  axis_frame_gen dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .enable      (enable),
    .frame_len   (frame_len),
    .gap_cycles  (gap_cycles),
    .m_axis      (axis_if),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame built as a flat byte array, then cut into beats.
  task automatic push_frame(input int len, input logic [31:0] seq);
    logic [7:0] hdr [18];
    beat_t bt;
    int nb, idx;
    for (int i = 0; i < 6; i++) hdr[i] = 8'hFF;
    hdr[6]  = 8'h00; hdr[7]  = 8'h0A; hdr[8]  = 8'h35;
    hdr[9]  = 8'h00; hdr[10] = 8'h00; hdr[11] = 8'h01;
    hdr[12] = 8'h88; hdr[13] = 8'hB5;
    hdr[14] = seq[31:24]; hdr[15] = seq[23:16]; hdr[16] = seq[15:8]; hdr[17] = seq[7:0];
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      bt = '0;
      for (int j = 0; j < 8; j++) begin
        idx = b * 8 + j;
        if (idx < len) begin
          bt.data[j*8 +: 8] = (idx < 18) ? hdr[idx] : idx[7:0];
          bt.keep[j] = 1'b1;
        end
      end
      bt.last = (b == nb - 1);
      exp_q.push_back(bt);
    end
  endtask

  // Minimum-length frame with sequence 0, written out by hand.
  task automatic push_min_frame_hand();
    exp_q.push_back('{64'h0A00_FFFF_FFFF_FFFF, 8'hFF, 1'b0});
    exp_q.push_back('{64'h0000_B588_0100_0035, 8'hFF, 1'b0});
    exp_q.push_back('{64'h1716_1514_1312_0000, 8'hFF, 1'b0});
    exp_q.push_back('{64'h1F1E_1D1C_1B1A_1918, 8'hFF, 1'b0});
    exp_q.push_back('{64'h2726_2524_2322_2120, 8'hFF, 1'b0});
    exp_q.push_back('{64'h2F2E_2D2C_2B2A_2928, 8'hFF, 1'b0});
    exp_q.push_back('{64'h3736_3534_3332_3130, 8'hFF, 1'b0});
    exp_q.push_back('{64'h0000_0000_3B3A_3938, 8'h0F, 1'b1});
  endtask

  // Monitor state
  bit    stall_prev = 1'b0;
  beat_t stall_bt;
  bit    in_frame = 1'b0;
  bit    gap_on = 1'b0;
  int    gap_cnt = 0;
  bit    chk_gap = 1'b0;
  int    exp_gap = 0;
  int    exp_fc = 0;
  bit    fc_pending = 1'b0;
  int    beat_idx = 0;
  beat_t e;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      stall_prev = 1'b0; in_frame = 1'b0; gap_on = 1'b0;
      exp_fc = 0; fc_pending = 1'b0; beat_idx = 0;
    end else begin
      if (fc_pending) begin
        check("frame_count_update", frame_count, exp_fc);
        fc_pending = 1'b0;
      end
      if (stall_prev)
        check("stall_hold", {axis_if.tx_tvalid, axis_if.tx_tlast, axis_if.tx_tkeep, axis_if.tx_tdata},
              {1'b1, stall_bt.last, stall_bt.keep, stall_bt.data});
      if (in_frame)
        check("tvalid_in_frame", axis_if.tx_tvalid, 1'b1);
      if (!busy) gap_on = 1'b0;
      if (axis_if.tx_tvalid) begin
        if (gap_on) begin
          if (chk_gap) check("gap_cycles", gap_cnt, exp_gap);
          gap_on = 1'b0;
        end
        in_frame   = 1'b1;
        stall_prev = !axis_if.tx_tready;
        stall_bt   = '{axis_if.tx_tdata, axis_if.tx_tkeep, axis_if.tx_tlast};
        if (axis_if.tx_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_beat: got %0h expected no beat at %0t", axis_if.tx_tdata, $time);
          end else begin
            e = exp_q.pop_front();
            check("tdata", axis_if.tx_tdata, e.data);
            check("tkeep", axis_if.tx_tkeep, e.keep);
            check("tlast", axis_if.tx_tlast, e.last);
          end
          beat_idx++;
          if (axis_if.tx_tlast) begin
            in_frame = 1'b0; beat_idx = 0; exp_fc++; fc_pending = 1'b1;
            gap_on = 1'b1; gap_cnt = 0;
          end
        end
      end else begin
        stall_prev = 1'b0;
        if (gap_on) gap_cnt++;
      end
    end
  end

  initial begin
    axis_if.tx_tready = 1'b1;
    forever begin
      @(posedge sys_clk); #1;
      axis_if.tx_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_last(input int n, input bit drop);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < 3000) begin
      @(negedge sys_clk); #1;
      cyc++;
      if (axis_if.tx_tvalid && axis_if.tx_tready && axis_if.tx_tlast) begin
        cnt++;
        if (cnt == n && drop) enable = 1'b0;
      end
    end
    if (cnt < n) begin
      n_checks++; n_fail++;
      $display("FAIL wait_last_timeout: got %0d frames expected %0d", cnt, n);
    end
  endtask

  task automatic wait_beats(input int n);
    int cyc = 0;
    do begin
      @(negedge sys_clk); #1;
      cyc++;
    end while (!(beat_idx >= n && axis_if.tx_tvalid) && cyc < 3000);
    if (cyc >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL wait_beats_timeout: got %0d beats expected %0d", beat_idx, n);
    end
  endtask

  task automatic settle_check(input int fc);
    repeat (12) @(posedge sys_clk);
    #1;
    check("busy_idle", busy, 1'b0);
    check("tvalid_idle", axis_if.tx_tvalid, 1'b0);
    check("frame_count", frame_count, fc);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_tvalid", axis_if.tx_tvalid, 1'b0);
    check("rst_tlast", axis_if.tx_tlast, 1'b0);
    check("rst_tuser", axis_if.tx_tuser, 1'b0);
    check("rst_tdata", axis_if.tx_tdata, 64'd0);
    check("rst_tkeep", axis_if.tx_tkeep, 8'd0);
    check("rst_frame_count", frame_count, 32'd0);
    check("rst_busy", busy, 1'b0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // Minimum length, back-to-back, start latency
    frame_len = 11'd60; gap_cycles = 16'd0; chk_gap = 1'b1; exp_gap = 0;
    push_min_frame_hand();
    push_frame(60, 32'd1);
    push_frame(60, 32'd2);
    enable = 1'b1;
    @(posedge sys_clk); #1;
    check("start_busy", busy, 1'b1);
    check("start_tvalid_low", axis_if.tx_tvalid, 1'b0);
    @(posedge sys_clk); #1;
    check("start_tvalid_high", axis_if.tx_tvalid, 1'b1);
    wait_last(3, 1'b1);
    settle_check(3);

    // Clamp to max, then a mid-frame length change clamps up to 60 for the next frame
    frame_len = 11'd2000;
    push_frame(1514, 32'd3);
    push_frame(60, 32'd4);
    enable = 1'b1;
    wait_beats(2);
    frame_len = 11'd5;
    wait_last(2, 1'b1);
    settle_check(5);

    // Backpressure with odd length
    frame_len = 11'd61;
    push_frame(61, 32'd5);
    push_frame(61, 32'd6);
    push_frame(61, 32'd7);
    rand_ready = 1'b1;
    enable = 1'b1;
    wait_last(3, 1'b1);
    rand_ready = 1'b0;
    settle_check(8);

    // Inter-frame gap
    frame_len = 11'd64; gap_cycles = 16'd5; exp_gap = 5;
    push_frame(64, 32'd8);
    push_frame(64, 32'd9);
    push_frame(64, 32'd10);
    enable = 1'b1;
    wait_last(3, 1'b1);
    settle_check(11);
    chk_gap = 1'b0;

    // Enable dropped mid-frame
    frame_len = 11'd80; gap_cycles = 16'd0;
    push_frame(80, 32'd11);
    enable = 1'b1;
    wait_beats(3);
    enable = 1'b0;
    wait_last(1, 1'b0);
    settle_check(12);

    // Reset mid-frame
    frame_len = 11'd60;
    push_frame(60, 32'd12);
    enable = 1'b1;
    wait_beats(4);
    sys_rst = 1'b1;
    exp_q.delete();
    @(negedge sys_clk); #1;
    check("rst_mid_tvalid", axis_if.tx_tvalid, 1'b0);
    check("rst_mid_frame_count", frame_count, 32'd0);
    check("rst_mid_busy", busy, 1'b0);
    push_frame(60, 32'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    wait_last(1, 1'b1);
    settle_check(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
